bnn_accum_tree: RTL

Parametrised, fully pipelined N-input signed adder tree followed by a multi-beat accumulator. It is the next generation of the fixed 64-input reduction used in the binary neural-net datapath: it sums one vector of partial popcounts per beat and accumulates successive beats of a packet until in_last. The block sits between the XNOR/popcount array and the threshold/activation stage, and emits one result per packet with valid, beat count and an optional saturation flag.

---
 rtl/bnn_accum_tree.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bnn_accum_tree.sv
// rtl/bnn_accum_tree.sv - pipelined N-input signed adder tree feeding a multi-beat packet accumulator
// Optional macro ACCUM_SAT_EN: clamp the accumulator to ACC_W and report a sticky per-packet out_sat flag.
module bnn_accum_tree #(
    parameter int N_IN   = 64,
    parameter int IN_W   = 19,
    parameter int ACC_W  = 26,
    parameter int BEAT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_data [N_IN],
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    in_clear,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_valid,
    output logic [BEAT_W-1:0]       out_beats,
    output logic                    out_sat
);
    localparam int L     = $clog2(N_IN);
    localparam int SUM_W = IN_W + L;

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    // Level k keeps N_IN>>k sums one bit wider than level k-1, so no level can overflow.
    genvar k;
    generate
        for (k = 1; k <= L; k++) begin : g_lvl
            localparam int W   = IN_W + k;
            localparam int CNT = N_IN >> k;
            logic signed [W-1:0] sum_q [CNT];

            if (k == 1) begin : g_leaf
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < CNT; i++) sum_q[i] <= '0;
                    end else begin
                        for (int i = 0; i < CNT; i++) begin
                            sum_q[i] <= {in_data[2*i][IN_W-1], in_data[2*i]}
                                      + {in_data[2*i+1][IN_W-1], in_data[2*i+1]};
                        end
                    end
                end
            end else begin : g_node
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < CNT; i++) sum_q[i] <= '0;
                    end else begin
                        for (int i = 0; i < CNT; i++) begin
                            sum_q[i] <= {g_lvl[k-1].sum_q[2*i][W-2], g_lvl[k-1].sum_q[2*i]}
                                      + {g_lvl[k-1].sum_q[2*i+1][W-2], g_lvl[k-1].sum_q[2*i+1]};
                        end
                    end
                end
            end
        end
    endgenerate

    // Bit 0 of each chain is the incoming beat; bit L is the beat leaving the tree.
    logic [L-1:0] vld_q;
    logic [L-1:0] last_q;
    logic [L:0]   vld_chain;
    logic [L:0]   last_chain;

    assign vld_chain  = {vld_q, in_valid & ~in_clear};
    assign last_chain = {last_q, in_valid & in_last};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= in_clear ? '0 : vld_chain[L-1:0];
            last_q <= last_chain[L-1:0];
        end
    end

    logic                     beat_vld;
    logic                     beat_last;
    logic signed [SUM_W-1:0]  tree_sum;
    logic signed [ACC_W-1:0]  beat_sum;

    assign beat_vld  = vld_chain[L];
    assign beat_last = last_chain[L];
    assign tree_sum  = g_lvl[L].sum_q[0];
    assign beat_sum  = ACC_W'(tree_sum);

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [BEAT_W-1:0]        cnt_q;
    logic [BEAT_W-1:0]        cnt_d;
    logic signed [ACC_W-1:0]  out_data_q;
    logic [BEAT_W-1:0]        out_beats_q;
    logic                     out_valid_q;

`ifdef ACCUM_SAT_EN
    logic signed [ACC_W:0]    wide_sum;
    logic                     clamp;
    logic                     sat_q;
    logic                     sat_d;
    logic                     out_sat_q;

    assign wide_sum = {acc_q[ACC_W-1], acc_q} + {beat_sum[ACC_W-1], beat_sum};
    assign clamp    = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    assign sat_d    = (state_q == S_ACCUM) ? (sat_q | clamp) : 1'b0;

    always_comb begin
        acc_sum = wide_sum[ACC_W-1:0];
        if (clamp) begin
            acc_sum = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else if (in_clear) begin
            sat_q <= 1'b0;
        end else if (beat_vld) begin
            sat_q <= sat_d;
            if (beat_last) begin
                out_sat_q <= sat_d;
            end
        end
    end

    assign out_sat = out_sat_q;
`else
    assign acc_sum = acc_q + beat_sum;
    assign out_sat = 1'b0;
`endif

    always_comb begin
        acc_d = beat_sum;
        cnt_d = BEAT_W'(1);
        if (state_q == S_ACCUM) begin
            acc_d = acc_sum;
            cnt_d = (cnt_q == {BEAT_W{1'b1}}) ? cnt_q : cnt_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
        end else if (in_clear) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (beat_vld) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                if (beat_last) begin
                    state_q     <= S_IDLE;
                    out_data_q  <= acc_d;
                    out_beats_q <= cnt_d;
                    out_valid_q <= 1'b1;
                end else begin
                    state_q <= S_ACCUM;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_valid = out_valid_q;

endmodule
